// File: rtl/isqrt_pkg.sv
// Shared types and helpers for the iterative integer square-root responder.
package isqrt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_DONE
  } isqrt_state_t;

  localparam int unsigned ISQRT_X_W_DEF = 32;

  function automatic int unsigned isqrt_latency(input int unsigned x_w);
    return x_w / 2 + 1;
  endfunction

endpackage

// File: rtl/isqrt_iter_step.sv
// One restoring digit-by-digit square-root iteration; purely combinational.
module isqrt_iter_step #(
  parameter int unsigned Y_W = 16
) (
  input  logic [Y_W+1:0] rem_i,
  input  logic [Y_W-1:0] root_i,
  input  logic [1:0]     bits_i,
  output logic [Y_W+1:0] rem_o,
  output logic [Y_W-1:0] root_o
);

  logic [Y_W+1:0] rem_sh;
  logic [Y_W+1:0] trial;
  logic           ge;

  always_comb begin
    rem_sh = (rem_i << 2) | {{Y_W{1'b0}}, bits_i};
    trial  = {root_i, 2'b01};
    ge     = (rem_sh >= trial);
    rem_o  = ge ? (rem_sh - trial) : rem_sh;
    root_o = (root_i << 1) | Y_W'(ge);
  end

endmodule

// File: rtl/isqrt_iter_fsm.sv
// Sequential floor(sqrt(x)) responder, one root bit per clock, fixed latency Y_W+1.
// Optional ISQRT_DROP_CNT_EN adds a saturating count of pulses ignored while busy.
module isqrt_iter_fsm
  import isqrt_pkg::*;
#(
  parameter int unsigned X_W = ISQRT_X_W_DEF,
  parameter int unsigned Y_W = X_W / 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           x_vld,
  input  logic [X_W-1:0] x,
  output logic           y_vld,
  output logic [Y_W-1:0] y
`ifdef ISQRT_DROP_CNT_EN
  ,
  output logic [7:0]     drop_cnt
`endif
);

  localparam int unsigned CntW = (Y_W > 1) ? $clog2(Y_W) : 1;

  isqrt_state_t   state_q, state_d;
  logic [X_W-1:0] x_q, x_d;
  logic [Y_W+1:0] rem_q, rem_d, rem_n;
  logic [Y_W-1:0] root_q, root_d, root_n;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [Y_W-1:0] y_q, y_d;
  logic           y_vld_q, y_vld_d;
  logic           load;

  isqrt_iter_step #(
    .Y_W (Y_W)
  ) u_step (
    .rem_i  (rem_q),
    .root_i (root_q),
    .bits_i (x_q[X_W-1 -: 2]),
    .rem_o  (rem_n),
    .root_o (root_n)
  );

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    rem_d   = rem_q;
    root_d  = root_q;
    cnt_d   = cnt_q;
    y_d     = y_q;
    y_vld_d = 1'b0;
    load    = 1'b0;

    case (state_q)
      ST_IDLE: load = x_vld;
      ST_CALC: begin
        x_d    = x_q << 2;
        rem_d  = rem_n;
        root_d = root_n;
        if (cnt_q == '0) begin
          state_d = ST_DONE;
          y_vld_d = 1'b1;
          y_d     = root_n;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      ST_DONE: begin
        // A pulse arriving in the result cycle is accepted without an idle bubble.
        load    = x_vld;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (load) begin
      x_d     = x;
      rem_d   = '0;
      root_d  = '0;
      cnt_d   = CntW'(Y_W - 1);
      state_d = ST_CALC;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      rem_q   <= '0;
      root_q  <= '0;
      cnt_q   <= '0;
      y_q     <= '0;
      y_vld_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      rem_q   <= rem_d;
      root_q  <= root_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
      y_vld_q <= y_vld_d;
    end
  end

  assign y     = y_q;
  assign y_vld = y_vld_q;

`ifdef ISQRT_DROP_CNT_EN
  logic [7:0] drop_q, drop_d;

  always_comb begin
    drop_d = drop_q;
    if ((state_q == ST_CALC) && x_vld && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_q <= '0;
    end else begin
      drop_q <= drop_d;
    end
  end

  assign drop_cnt = drop_q;
`endif

endmodule

// File: tb/tb_isqrt_iter_fsm.sv
// Scoreboard bench for isqrt_iter_fsm: expected roots and arrival cycles are queued at send time.
module tb_isqrt_iter_fsm;

  localparam int unsigned XW  = 32;
  localparam int unsigned YW  = 16;
  localparam int          LAT = 17;

  logic          clk;
  logic          rst_n;
  logic          x_vld;
  logic [XW-1:0] x;
  logic          y_vld;
  logic [YW-1:0] y;
`ifdef ISQRT_DROP_CNT_EN
  logic [7:0]    drop_cnt;
`endif

  typedef struct {
    logic [YW-1:0] y;
    int            cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc;
  int   total;
  int   bad;

  isqrt_iter_fsm #(
    .X_W (XW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .x_vld    (x_vld),
    .x        (x),
    .y_vld    (y_vld),
    .y        (y)
`ifdef ISQRT_DROP_CNT_EN
    ,
    .drop_cnt (drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s obs=%0h exp=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Bit-at-a-time from the top: largest r with r*r <= v.
  function automatic logic [YW-1:0] ref_isqrt(input logic [XW-1:0] v);
    logic [63:0] r, t;
    r = 0;
    for (int b = YW - 1; b >= 0; b--) begin
      t = r | (64'd1 << b);
      if (t * t <= {32'd0, v}) r = t;
    end
    return r[YW-1:0];
  endfunction

  always @(negedge clk) begin
    if (rst_n && y_vld) begin
      if (exp_q.size() == 0) begin
        check("spurious_vld", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("y", {48'd0, y}, {48'd0, e.y});
        check("latency", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  // Drives one pulse at the current negedge and returns one negedge later.
  task automatic send(input logic [XW-1:0] v, input bit accepted);
    exp_t e;
    x_vld = 1'b1;
    x     = v;
    if (accepted) begin
      e.y   = ref_isqrt(v);
      e.cyc = cyc + LAT;
      exp_q.push_back(e);
    end
    @(negedge clk);
    x_vld = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    logic [XW-1:0] singles[5];
    logic [XW-1:0] v;
    int            g;
    logic [31:0]   r;

    singles = '{32'd1, 32'd15, 32'd16, 32'd1000000, 32'hFFFF_FFFF};
    total   = 0;
    bad     = 0;
    rst_n   = 1'b0;
    x_vld   = 1'b0;
    x       = '0;
    #1;
    check("rst_y_vld", {63'd0, y_vld}, 64'd0);
    check("rst_y", {48'd0, y}, 64'd0);
`ifdef ISQRT_DROP_CNT_EN
    check("rst_drop", {56'd0, drop_cnt}, 64'd0);
`endif
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    send(32'd0, 1'b1);
    drain(40);

    foreach (singles[i]) begin
      send(singles[i], 1'b1);
      drain(40);
    end

    // Second pulse lands in the result cycle of the first.
    send(32'd144, 1'b1);
    repeat (LAT - 1) @(negedge clk);
    check("b2b_done_vld", {63'd0, y_vld}, 64'd1);
    send(32'd169, 1'b1);
    drain(60);

    send(32'd81, 1'b1);
    repeat (2) @(negedge clk);
    send(32'd4, 1'b0);
    drain(40);
`ifdef ISQRT_DROP_CNT_EN
    check("drop_one", {56'd0, drop_cnt}, 64'd1);
`endif

    send(32'd100, 1'b0);
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async_rst_y", {48'd0, y}, 64'd0);
    check("async_rst_vld", {63'd0, y_vld}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    send(32'd49, 1'b1);
    drain(40);

    for (int i = 0; i < 2500; i++) begin
      r = $urandom;
      case ($urandom_range(0, 3))
        0: v = 32'($urandom_range(0, 1000));
        1: v = {16'd0, r[15:0]} * {16'd0, r[15:0]};
        2: v = {16'd0, r[15:0]} * {16'd0, r[15:0]} - 32'd1;
        default: v = $urandom;
      endcase
      g = $urandom_range(0, 3);
      send(v, 1'b1);
      repeat (LAT - 1 + g) @(negedge clk);
    end
    drain(60);

`ifdef ISQRT_DROP_CNT_EN
    // Held-high valid: accepted only from idle and in each result cycle.
    for (int i = 0; i < 300; i++) begin
      exp_t e;
      x_vld = 1'b1;
      x     = 32'(i) * 32'd7919;
      if (i % LAT == 0) begin
        e.y   = ref_isqrt(x);
        e.cyc = cyc + LAT;
        exp_q.push_back(e);
      end
      @(negedge clk);
    end
    x_vld = 1'b0;
    drain(60);
    check("drop_sat", {56'd0, drop_cnt}, 64'd255);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
